// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-outstanding memory port between the instruction-fetch
// requester (I) and the load/store requester (D). D has priority, but after
// STARVE_LIM consecutive D grants with I waiting, I is granted. All outputs
// are registered.
//
// Optional build macro: ARB_TIMEOUT_EN
//   When defined, an access that sees no m_ack_i for TIMEOUT BUSY cycles is
//   aborted: the owner gets rdata 32'hDEAD_BEEF with rvalid and err_o.
//   When undefined, the arbiter waits indefinitely and err_o is tied low.
//
// state  | meaning
// IDLE   | no transaction, arbitrating every cycle
// BUSY_I | fetch access outstanding on the memory port
// BUSY_D | load/store access outstanding on the memory port
// RESP   | owner's rvalid cycle; arbitrates for the next access
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [3:0]        d_wstrb_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [31:0]       m_wdata_o,
  output logic [3:0]        m_wstrb_o,
  input  logic              m_ack_i,
  input  logic [31:0]       m_rdata_i,
  output logic              err_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  logic [1:0]        state_q, state_d;
  logic [3:0]        d_streak_q, d_streak_d;
  logic              if_gnt_q, if_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              d_gnt_q, d_gnt_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic [3:0]        m_wstrb_q, m_wstrb_d;

  logic win_d, win_i;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Arbitration decision: D wins unless I has been starved STARVE_LIM times.
  always_comb begin
    win_d = d_req_i && (!if_req_i || (d_streak_q < LIM));
    win_i = if_req_i && !win_d;
  end

  // Next-state and next-output logic for the whole arbiter.
  always_comb begin
    state_d     = state_q;
    d_streak_d  = d_streak_q;
    if_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_gnt_d     = 1'b0;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
`ifdef ARB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    err_d       = 1'b0;
`endif

    case (state_q)
      IDLE, RESP: begin
        if (win_d) begin
          state_d    = BUSY_D;
          d_gnt_d    = 1'b1;
          m_req_d    = 1'b1;
          m_we_d     = d_we_i;
          m_addr_d   = d_addr_i;
          m_wdata_d  = d_wdata_i;
          m_wstrb_d  = d_wstrb_i;
          if (if_req_i) begin
            d_streak_d = (d_streak_q == LIM) ? LIM : d_streak_q + 4'd1;
          end else begin
            d_streak_d = 4'd0;
          end
`ifdef ARB_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end else if (win_i) begin
          state_d    = BUSY_I;
          if_gnt_d   = 1'b1;
          m_req_d    = 1'b1;
          m_we_d     = 1'b0;
          m_addr_d   = if_addr_i;
          m_wdata_d  = 32'd0;
          m_wstrb_d  = 4'd0;
          d_streak_d = 4'd0;
`ifdef ARB_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      BUSY_I, BUSY_D: begin
        if (m_ack_i) begin
          state_d = RESP;
          m_req_d = 1'b0;
          if (state_q == BUSY_D) begin
            d_rdata_d  = m_rdata_i;
            d_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = m_rdata_i;
            if_rvalid_d = 1'b1;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_LIM) begin
          state_d = RESP;
          m_req_d = 1'b0;
          err_d   = 1'b1;
          if (state_q == BUSY_D) begin
            d_rdata_d  = 32'hDEAD_BEEF;
            d_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = 32'hDEAD_BEEF;
            if_rvalid_d = 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      d_streak_q  <= 4'd0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_gnt_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= 32'd0;
      m_wstrb_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      d_streak_q  <= d_streak_d;
      if_gnt_q    <= if_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_gnt_q     <= d_gnt_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Timeout counter and abort flag.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign if_gnt_o    = if_gnt_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_gnt_o     = d_gnt_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_rdata_o   = d_rdata_q;
  assign m_req_o     = m_req_q;
  assign m_we_o      = m_we_q;
  assign m_addr_o    = m_addr_q;
  assign m_wdata_o   = m_wdata_q;
  assign m_wstrb_o   = m_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .STARVE_LIM(4), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .m_req_o(m_req), .m_we_o(m_we), .m_addr_o(m_addr),
    .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
    .m_ack_i(m_ack), .m_rdata_i(m_rdata),
    .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Concatenated control outputs, handy for all-zero checks.
  function automatic logic [31:0] ctl();
    return {20'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, m_req, m_we, m_wstrb, err, 1'b0};
  endfunction

  logic exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic got_d [10];
  int   n_gnt;

  initial begin
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h4;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0;
    m_ack = 1'b0; m_rdata = 32'd0;

    // Reset held for two edges with if_req high.
    tick(); tick();
    chk("rst_ctl", ctl(), 32'd0);
    chk("rst_maddr", m_addr, 32'd0);
    chk("rst_mwdata", m_wdata, 32'd0);
    chk("rst_ifrdata", if_rdata, 32'd0);
    chk("rst_drdata", d_rdata, 32'd0);
    rst = 1'b1;

    // Fetch 0x4 granted right after release, m_ack after 3 extra cycles.
    tick();
    chk("f_gnt", {31'd0, if_gnt}, 32'd1);
    chk("f_dgnt", {31'd0, d_gnt}, 32'd0);
    chk("f_mreq1", {31'd0, m_req}, 32'd1);
    chk("f_maddr", m_addr, 32'h4);
    chk("f_mwe", {31'd0, m_we}, 32'd0);
    if_req = 1'b0;
    tick();
    chk("f_gnt_pulse", {31'd0, if_gnt}, 32'd0);
    chk("f_mreq2", {31'd0, m_req}, 32'd1);
    tick();
    chk("f_mreq3", {31'd0, m_req}, 32'd1);
    chk("f_norv3", {31'd0, if_rvalid}, 32'd0);
    tick();
    chk("f_mreq4", {31'd0, m_req}, 32'd1);
    chk("f_maddr4", m_addr, 32'h4);
    m_ack = 1'b1; m_rdata = 32'hCAFE_F00D;
    tick();
    chk("f_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("f_rdata", if_rdata, 32'hCAFE_F00D);
    chk("f_mreq_lo", {31'd0, m_req}, 32'd0);
    chk("f_no_drv", {31'd0, d_rvalid}, 32'd0);
    m_ack = 1'b0;
    tick();
    chk("f_rvalid_once", {31'd0, if_rvalid}, 32'd0);
    chk("f_rdata_hold", if_rdata, 32'hCAFE_F00D);

    // Load 0x100 with immediate ack.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    tick();
    chk("ld_gnt", {31'd0, d_gnt}, 32'd1);
    chk("ld_mreq", {31'd0, m_req}, 32'd1);
    chk("ld_maddr", m_addr, 32'h100);
    chk("ld_mwe", {31'd0, m_we}, 32'd0);
    d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h1234_5678;
    tick();
    chk("ld_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("ld_rdata", d_rdata, 32'h1234_5678);
    chk("ld_no_ifrv", {31'd0, if_rvalid}, 32'd0);
    chk("ld_ifrdata_hold", if_rdata, 32'hCAFE_F00D);
    m_ack = 1'b0;
    tick();
    chk("ld_rvalid_once", {31'd0, d_rvalid}, 32'd0);

    // Store 0xAABBCCDD to 0x20, then load it back (arbitrated out of RESP).
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hAABB_CCDD; d_wstrb = 4'hF;
    tick();
    chk("st_gnt", {31'd0, d_gnt}, 32'd1);
    chk("st_mwe", {31'd0, m_we}, 32'd1);
    chk("st_maddr", m_addr, 32'h20);
    chk("st_mwdata", m_wdata, 32'hAABB_CCDD);
    chk("st_mwstrb", {28'd0, m_wstrb}, 32'hF);
    d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h0;
    tick();
    chk("st_rvalid", {31'd0, d_rvalid}, 32'd1);
    d_req = 1'b1; d_we = 1'b0; d_wdata = 32'h0; d_wstrb = 4'h0; m_ack = 1'b0;
    tick();
    chk("rd_gnt", {31'd0, d_gnt}, 32'd1);
    chk("rd_mwe", {31'd0, m_we}, 32'd0);
    chk("rd_maddr", m_addr, 32'h20);
    chk("rd_no_rv", {31'd0, d_rvalid}, 32'd0);
    d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hAABB_CCDD;
    tick();
    chk("rd_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("rd_rdata", d_rdata, 32'hAABB_CCDD);
    m_ack = 1'b0;
    tick();

    // Contention: both requesting continuously, memory acks immediately.
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h0102_0304; d_wstrb = 4'b0011;
    m_ack = 1'b1; m_rdata = 32'h5A5A_5A5A;
    n_gnt = 0;
    for (int c = 0; c < 40 && n_gnt < 10; c++) begin
      tick();
      chk("c_gnt_excl", {31'd0, if_gnt & d_gnt}, 32'd0);
      chk("c_rv_excl", {31'd0, if_rvalid & d_rvalid}, 32'd0);
      if (if_gnt || d_gnt) begin
        got_d[n_gnt] = d_gnt;
        chk("c_wstrb", {28'd0, m_wstrb}, d_gnt ? 32'h3 : 32'h0);
        chk("c_mwe", {31'd0, m_we}, d_gnt ? 32'd1 : 32'd0);
        n_gnt++;
      end
    end
    chk("c_n_gnt", n_gnt, 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < n_gnt) chk("c_order", {31'd0, got_d[i]}, {31'd0, exp_d[i]});
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'd0;
    tick();
    tick();
    chk("c_quiet", {31'd0, if_gnt | d_gnt}, 32'd0);
    m_ack = 1'b0;
    tick();

    // Reset while BUSY_D: access abandoned, late m_ack ignored.
    d_req = 1'b1; d_addr = 32'h44;
    tick();
    chk("r_gnt", {31'd0, d_gnt}, 32'd1);
    d_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("r_ctl", ctl(), 32'd0);
    chk("r_drdata", d_rdata, 32'd0);
    chk("r_maddr", m_addr, 32'd0);
    rst = 1'b1; m_ack = 1'b1; m_rdata = 32'h55;
    tick();
    chk("r_late_ack", ctl(), 32'd0);
    chk("r_late_rdata", d_rdata, 32'd0);
    m_ack = 1'b0;
    tick();
    chk("r_idle", ctl(), 32'd0);

    // Memory never acks a fetch.
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    chk("t_gnt", {31'd0, if_gnt}, 32'd1);
    if_req = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk("t_wait_rv", {31'd0, if_rvalid}, 32'd0);
    end
    tick();
    chk("t_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t_err", {31'd0, err}, 32'd1);
    chk("t_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("t_mreq", {31'd0, m_req}, 32'd0);
    m_ack = 1'b1;
    tick();
    chk("t_late_ack", {31'd0, if_rvalid | err}, 32'd0);
    m_ack = 1'b0;
`else
    for (int k = 2; k <= 20; k++) begin
      tick();
      chk("t_mreq_hold", {31'd0, m_req}, 32'd1);
      chk("t_no_err", {31'd0, err | if_rvalid}, 32'd0);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("t_cleared", ctl(), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
